// File: rtl/mips_pkg.sv
// mips_pkg: shared types and widths for the boot-time program loader.
//   loader_state_e : loader FSM states (LOAD, DONE, ERROR)
//   WORD_W         : instruction word width (32)
//   BYTE_W         : program byte width (8)
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: gathers accepted bytes into a 32-bit word.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : discard any partial word (used on restart)
//   accept    : a byte is consumed this cycle
//   in_data   : the byte being consumed
//   in_last   : the byte is the final one of the image
//   commit    : this accept completes a word (lane 3 filled, or last byte)
//   word      : assembly register with the current byte already merged in,
//               valid to register whenever commit is high
module byte_packer
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              commit,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [1:0]        lane;
  logic [WORD_W-1:0] merged;

  always_comb begin
    // Big-endian puts byte 0 in the top lane, matching MIPS memory order.
    lane   = BIG_ENDIAN ? (2'd3 - byte_idx_q) : byte_idx_q;
    merged = asm_q;
    case (lane)
      2'd0:    merged[7:0]   = in_data;
      2'd1:    merged[15:8]  = in_data;
      2'd2:    merged[23:16] = in_data;
      default: merged[31:24] = in_data;
    endcase

    commit = accept && ((byte_idx_q == 2'd3) || in_last);
    word   = merged;

    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    if (clr || commit) begin
      // Clearing on the commit edge lets the next byte start a fresh word
      // in the very next cycle, so unfilled lanes of a short word read 0.
      byte_idx_d = 2'd0;
      asm_d      = '0;
    end else if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      asm_d      = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the IF stage.
// Receives a byte stream, assembles 32-bit instruction words and writes them
// to instruction memory at word addresses 0,1,2,...; holds the core in reset
// (core_run = 0) until the final word is written.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready : byte stream input
//   restart     : pulse, honoured only in DONE or ERROR
//   imem_we/imem_addr/imem_wdata      : one-cycle write per word
//   core_run    : 1 = core released
//   word_count  : words written in the current load
//   error       : image exceeded 2**ADDR_WIDTH words
//   dbg_state   : loader FSM state
//
// Handshake: a byte transfers on every rising edge where in_valid && in_ready
// are both high; in_ready does not depend on in_valid, and a byte offered
// while in_ready is low stays with the producer.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  core_run,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  error,
  output loader_state_e         dbg_state
);

  // word_count value meaning the memory (2**ADDR_WIDTH words) is full.
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  loader_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic                    last_pend_q, last_pend_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0]       imem_wdata_q, imem_wdata_d;

  logic                    full;
  logic                    take;
  logic                    pk_accept;
  logic                    pk_clr;
  logic                    pk_commit;
  logic [WORD_W-1:0]       pk_word;

  byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .accept  (pk_accept),
    .in_data (in_data),
    .in_last (in_last),
    .commit  (pk_commit),
    .word    (pk_word)
  );

  always_comb begin
    full = (word_count_q == FULL_COUNT);
    // in_ready drops during the final write cycle so nothing past the
    // image's last byte is consumed; otherwise it stays high while loading.
    in_ready  = (state_q == LOAD) && !last_pend_q;
    take      = in_valid && in_ready;
    // A byte arriving with memory full is consumed but discarded.
    pk_accept = take && !full;
    pk_clr    = restart && (state_q != LOAD);

    state_d      = state_q;
    word_count_d = word_count_q;
    last_pend_d  = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      LOAD: begin
        // The final write is on the bus this cycle; release the core next.
        if (last_pend_q) state_d = DONE;
        if (take && full) state_d = ERROR;
        if (pk_commit) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
          imem_wdata_d = pk_word;
          word_count_d = word_count_q + COUNT_ONE;
          last_pend_d  = in_last;
        end
      end
      DONE, ERROR: begin
        if (restart) begin
          state_d      = LOAD;
          word_count_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      word_count_q <= '0;
      last_pend_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      last_pend_q  <= last_pend_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign core_run   = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Two instances share one
// input stream: a big-endian one (main checks) and a little-endian one.
// Memory depth is 4 words so the overflow case stays short.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        restart;

  logic          be_ready, be_we, be_run, be_error;
  logic [AW-1:0] be_addr;
  logic [31:0]   be_wdata;
  logic [AW:0]   be_count;
  loader_state_e be_state;

  logic          le_ready, le_we, le_run, le_error;
  logic [AW-1:0] le_addr;
  logic [31:0]   le_wdata;
  logic [AW:0]   le_count;
  loader_state_e le_state;

  imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(be_ready), .restart(restart),
    .imem_we(be_we), .imem_addr(be_addr), .imem_wdata(be_wdata),
    .core_run(be_run), .word_count(be_count), .error(be_error),
    .dbg_state(be_state)
  );

  imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(le_ready), .restart(restart),
    .imem_we(le_we), .imem_addr(le_addr), .imem_wdata(le_wdata),
    .core_run(le_run), .word_count(le_count), .error(le_error),
    .dbg_state(le_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_le_q[$];
  logic [63:0] got_be_q[$];
  logic [63:0] got_le_q[$];
  logic [7:0]  img_q[$];

  function automatic logic [63:0] wr(input int a, input logic [31:0] d);
    return {32'(a), d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (be_we) got_be_q.push_back({32'(be_addr), be_wdata});
    if (le_we) got_le_q.push_back({32'(le_addr), le_wdata});
  end

  task automatic clear_writes;
    got_be_q.delete();
    got_le_q.delete();
  endtask

  task automatic compare_be(input string tag);
    check({tag, "_be_nwr"}, 64'(got_be_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_be_q.size()) check($sformatf("%s_be_wr%0d", tag, i), got_be_q[i], exp_q[i]);
    end
  endtask

  task automatic compare_le(input string tag);
    check({tag, "_le_nwr"}, 64'(got_le_q.size()), 64'(exp_le_q.size()));
    foreach (exp_le_q[i]) begin
      if (i < got_le_q.size()) check($sformatf("%s_le_wr%0d", tag, i), got_le_q[i], exp_le_q[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one byte and returns #1 after the edge that accepts it.
  task automatic send(input logic [7:0] d, input logic last, input int stall_max);
    int guard;
    guard = 0;
    @(negedge clk);
    repeat ($urandom_range(stall_max, 0)) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!be_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) check("ready_timeout", 64'(be_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_img(input logic with_last, input int stall_max);
    foreach (img_q[i]) send(img_q[i], with_last && (i == img_q.size() - 1), stall_max);
  endtask

  // Counts clock cycles from the last accept until core_run is seen.
  task automatic wait_run(output int n);
    n = 0;
    while (!be_run && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_restart;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    do_reset;

    // Reset values
    check("rst_ready", 64'(be_ready), 64'(1));
    check("rst_we",    64'(be_we),    64'(0));
    check("rst_addr",  64'(be_addr),  64'(0));
    check("rst_wdata", 64'(be_wdata), 64'(0));
    check("rst_run",   64'(be_run),   64'(0));
    check("rst_count", 64'(be_count), 64'(0));
    check("rst_error", 64'(be_error), 64'(0));
    check("rst_state", 64'(be_state), 64'(LOAD));

    // Two full words back-to-back
    clear_writes();
    img_q = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02};
    send_img(1'b1, 0);
    wait_run(n);
    check("t1_latency", 64'(n), 64'(2));
    exp_q    = '{wr(0, 32'h3C080001), wr(1, 32'h21090002)};
    exp_le_q = '{wr(0, 32'h0100083C), wr(1, 32'h02000921)};
    compare_be("t1");
    compare_le("t1");
    check("t1_count", 64'(be_count), 64'(2));
    check("t1_state", 64'(be_state), 64'(DONE));
    check("t1_ready", 64'(be_ready), 64'(0));

    // Offered bytes in DONE are not consumed
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("t1_idle_nwr", 64'(got_be_q.size()), 64'(2));
    check("t1_idle_count", 64'(be_count), 64'(2));

    // Restart from DONE, then a short final word
    pulse_restart;
    check("t2_rs_run",   64'(be_run),   64'(0));
    check("t2_rs_count", 64'(be_count), 64'(0));
    check("t2_rs_state", 64'(be_state), 64'(LOAD));
    check("t2_rs_ready", 64'(be_ready), 64'(1));
    clear_writes();
    img_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send_img(1'b1, 0);
    wait_run(n);
    check("t2_latency", 64'(n), 64'(2));
    exp_q    = '{wr(0, 32'h11121314), wr(1, 32'h15000000)};
    exp_le_q = '{wr(0, 32'h14131211), wr(1, 32'h00000015)};
    compare_be("t2");
    compare_le("t2");
    check("t2_state", 64'(be_state), 64'(DONE));

    // Lane order
    pulse_restart;
    clear_writes();
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_img(1'b1, 0);
    wait_run(n);
    exp_q    = '{wr(0, 32'hAABBCCDD)};
    exp_le_q = '{wr(0, 32'hDDCCBBAA)};
    compare_be("t3");
    compare_le("t3");

    // Exactly full memory with last is legal
    do_reset;
    clear_writes();
    img_q.delete();
    for (int i = 0; i < 16; i++) img_q.push_back(8'(8'h40 + i));
    send_img(1'b1, 0);
    wait_run(n);
    exp_q = '{wr(0, 32'h40414243), wr(1, 32'h44454647),
              wr(2, 32'h48494A4B), wr(3, 32'h4C4D4E4F)};
    compare_be("t4");
    check("t4_state", 64'(be_state), 64'(DONE));
    check("t4_error", 64'(be_error), 64'(0));
    check("t4_count", 64'(be_count), 64'(4));

    // One byte too many: dropped, ERROR
    pulse_restart;
    clear_writes();
    img_q.delete();
    for (int i = 0; i < 17; i++) img_q.push_back(8'(8'h80 + i));
    send_img(1'b0, 0);
    repeat (3) @(negedge clk);
    exp_q = '{wr(0, 32'h80818283), wr(1, 32'h84858687),
              wr(2, 32'h88898A8B), wr(3, 32'h8C8D8E8F)};
    compare_be("t4ov");
    check("t4ov_error", 64'(be_error), 64'(1));
    check("t4ov_run",   64'(be_run),   64'(0));
    check("t4ov_state", 64'(be_state), 64'(ERROR));
    check("t4ov_count", 64'(be_count), 64'(4));
    check("t4ov_ready", 64'(be_ready), 64'(0));
    pulse_restart;
    check("t4ov_rs_error", 64'(be_error), 64'(0));
    check("t4ov_rs_state", 64'(be_state), 64'(LOAD));
    check("t4ov_rs_count", 64'(be_count), 64'(0));

    // Reset in the middle of the second word
    do_reset;
    clear_writes();
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_img(1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_count", 64'(be_count), 64'(0));
    check("t5_we",    64'(be_we),    64'(0));
    @(negedge clk);
    rst = 1'b0;
    img_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_img(1'b1, 0);
    wait_run(n);
    check("t5_latency", 64'(n), 64'(2));
    exp_q = '{wr(0, 32'h01020304), wr(0, 32'hDEADBEEF)};
    compare_be("t5");

    // Random stalls give the same result as back-to-back
    do_reset;
    clear_writes();
    img_q = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02};
    send_img(1'b1, 3);
    wait_run(n);
    check("t6_latency", 64'(n), 64'(2));
    exp_q    = '{wr(0, 32'h3C080001), wr(1, 32'h21090002)};
    exp_le_q = '{wr(0, 32'h0100083C), wr(1, 32'h02000921)};
    compare_be("t6");
    compare_le("t6");
    check("t6_count", 64'(be_count), 64'(2));
    pulse_restart;
    check("t6_rs_run", 64'(be_run), 64'(0));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the pipeline's IF stage.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit MIPS instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the core in reset through core_run until the last byte is committed, then releases it.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; capacity DEPTH = 2**ADDR_WIDTH words.
- BIG_ENDIAN, 1, 1 = first byte of each word goes to [31:24] (MIPS order); 0 = first byte goes to [7:0].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  program byte.
- in_last  in  1  qualifies in_data as the final byte of the image.
- in_ready  out  1  loader can accept a byte this cycle.
- restart  in  1  single-cycle pulse; only acted on in DONE or ERROR.
- imem_we  out  1  instruction-memory write strobe, exactly one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  assembled word.
- core_run  out  1  1 = core released (core reset = ~core_run).
- word_count  out  ADDR_WIDTH+1  number of words written in the current load.
- error  out  1  overflow: image larger than DEPTH words.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State = LOAD; in_ready = 1.
  - imem_we = 0; imem_addr = 0; imem_wdata = 0.
  - core_run = 0; word_count = 0; error = 0.
  - Byte index = 0; assembly register = 0.
- Reset mid-load discards partial state immediately. Memory contents are untouched.
- States:
  - LOAD: accepts bytes.
  - DONE: core_run = 1, in_ready = 0.
  - ERROR: core_run = 0, in_ready = 0, error = 1.
- Accept: a byte is accepted when in_valid && in_ready. It is placed in lane byte_idx; the lane order is set by BIG_ENDIAN. byte_idx then increments modulo 4.
- Word commit: triggered on acceptance of byte_idx == 3, or of any byte with in_last = 1.
  - On the next cycle: imem_we = 1, imem_addr = word_count[ADDR_WIDTH-1:0], imem_wdata = assembled word. Lanes not filled are zero.
  - word_count increments in that same cycle.
  - The assembly register and byte_idx clear on the commit edge, so a byte accepted during the write cycle starts the next word with no bubble.
- in_ready stays 1 during the write cycle, giving a sustained throughput of one byte per clock.
- in_last handling:
  - After the final commit's write cycle, the state moves to DONE.
  - core_run rises in the cycle after the last imem_we. Latency from the accept of the final byte to core_run = 2 cycles.
  - in_last on byte 0 of a word commits a word containing only that one byte.
- Overflow: a byte accepted while word_count == DEPTH is dropped. State moves to ERROR, error = 1, and no write occurs. A full image of exactly DEPTH words ending with in_last is legal and goes to DONE.
- restart:
  - In DONE or ERROR: next cycle state = LOAD, core_run = 0, error = 0, word_count = 0, byte_idx = 0.
  - Ignored in LOAD.
- Simultaneous rst and restart: rst wins.
- in_valid while not in_ready: no effect; the byte is not consumed.

Decomposition:
- Shared package (mips_pkg): loader state enum (LOAD, DONE, ERROR), WORD_W = 32, BYTE_W = 8.
- One natural sub-module, byte_packer:
  - Contains the byte_idx counter, lane steering per BIG_ENDIAN, and the commit pulse.
  - The top-level loader holds the FSM, address counter and memory-write register.

Test Plan:
- 8 bytes 0x3C,0x08,0x00,0x01,0x21,0x09,0x00,0x02 back-to-back, last on the 8th, BIG_ENDIAN = 1 → imem writes addr0 = 0x3C080001, addr1 = 0x21090002; core_run rises 2 cycles after the last accept; word_count = 2.
- 5 bytes 0x11..0x15, last on 0x15 → addr0 = 0x11121314, addr1 = 0x15000000; DONE.
- BIG_ENDIAN = 0, bytes 0xAA,0xBB,0xCC,0xDD, last → addr0 = 0xDDCCBBAA.
- ADDR_WIDTH = 2: 16 bytes with last on the 16th → 4 writes, DONE, error = 0. Then restart, followed by 17 bytes → 4 writes, 17th byte dropped, error = 1, core_run = 0.
- rst asserted after 6 bytes → next cycle word_count = 0, no pending write. A fresh 4-byte image then lands at addr0.
- in_valid toggled randomly (stalls) → identical imem contents and write count versus the back-to-back case; restart from DONE drops core_run within 1 cycle.
